// File: rtl/ecc_affine_conv_if.sv
// Handshake and data bundle between the scalar-multiplication top and the
// projective-to-affine converter.
interface ecc_affine_conv_if #(
  parameter int W = 176
) ();
  logic         conv_start;
  logic [W-1:0] x_in;
  logic [W-1:0] z_in;
  logic [W-1:0] aff_x;
  logic         conv_busy;
  logic         conv_done;
  logic         conv_err;

  modport master (
    output conv_start, x_in, z_in,
    input  aff_x, conv_busy, conv_done, conv_err
  );

  modport slave (
    input  conv_start, x_in, z_in,
    output aff_x, conv_busy, conv_done, conv_err
  );
endinterface

// File: rtl/ecc_affine_conv.sv
// Converts a projective GF(2^163) pair (X, Z) to affine x = X / Z using an
// iterative binary modular-division datapath.
module ecc_affine_conv #(
  parameter int           M    = 163,
  parameter int           W    = 176,
  parameter logic [163:0] POLY = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9
) (
  input  logic               clk,
  input  logic               rst_n,
  ecc_affine_conv_if.slave   conv
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t       state_r, state_s;
  logic [M:0]   a_r, a_s;
  logic [M:0]   b_r, b_s;
  logic [M:0]   u_r, u_s;
  logic [M:0]   v_r, v_s;
  logic [M:0]   a_xor_b_s;
  logic [M:0]   u_xor_v_s;
  logic [M-1:0] aff_r, aff_s;
  logic         err_r, err_s;
  logic         busy_r, busy_s;
  logic         done_r, done_s;
  logic         unused_pad_s;

  // Multiplication by t^-1 mod f: fold in f when odd so the shift is exact.
  function automatic logic [M:0] half_f(input logic [M:0] p);
    logic [M:0] q;
    if (p[0]) begin
      q = (p ^ POLY) >> 1;
    end else begin
      q = p >> 1;
    end
    return q;
  endfunction

  assign a_xor_b_s    = a_r ^ b_r;
  assign u_xor_v_s    = u_r ^ v_r;
  assign unused_pad_s = ^{conv.x_in[W-1:M], conv.z_in[W-1:M]};

  // Next-state and datapath selection; X and Z are latched straight into u and a.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    u_s     = u_r;
    v_s     = v_r;
    aff_s   = aff_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (conv.conv_start) begin
          u_s     = {1'b0, conv.x_in[M-1:0]};
          a_s     = {1'b0, conv.z_in[M-1:0]};
          state_s = ST_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (a_r == {(M+1){1'b0}}) begin
          err_s   = 1'b1;
          aff_s   = {M{1'b0}};
          state_s = ST_DONE;
        end else begin
          err_s   = 1'b0;
          b_s     = POLY;
          v_s     = {(M+1){1'b0}};
          state_s = ST_ITER;
        end
      end
      ST_ITER: begin
        if (a_r == b_r) begin
          aff_s   = u_r[M-1:0];
          state_s = ST_DONE;
        end else if (!a_r[0]) begin
          a_s = a_r >> 1;
          u_s = half_f(u_r);
        end else if (!b_r[0]) begin
          b_s = b_r >> 1;
          v_s = half_f(v_r);
        end else if (a_r > b_r) begin
          a_s = a_xor_b_s >> 1;
          u_s = half_f(u_xor_v_s);
        end else begin
          b_s = a_xor_b_s >> 1;
          v_s = half_f(u_xor_v_s);
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_DONE);
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      a_r     <= {(M+1){1'b0}};
      b_r     <= {(M+1){1'b0}};
      u_r     <= {(M+1){1'b0}};
      v_r     <= {(M+1){1'b0}};
      aff_r   <= {M{1'b0}};
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      u_r     <= u_s;
      v_r     <= v_s;
      aff_r   <= aff_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign conv.aff_x     = {{(W-M){1'b0}}, aff_r};
  assign conv.conv_busy = busy_r;
  assign conv.conv_done = done_r;
  assign conv.conv_err  = err_r;

endmodule

// File: tb/tb_ecc_affine_conv.sv
// Scoreboard bench for ecc_affine_conv: driver queues expectations, a monitor
// checks each conv_done against them.
module tb_ecc_affine_conv;

  localparam int           M    = 163;
  localparam int           W    = 176;
  localparam logic [163:0] POLY = 164'h8_0000_0000_0000_0000_0000_0000_0000_0000_0000_00C9;
  localparam logic [162:0] GX   = 163'h2FE13C0537BBC11ACAA07D793DE4E6D5E5C94EEE8;
  // t^-1 mod f, i.e. (1 ^ f) >> 1
  localparam logic [162:0] TINV = 163'h4_0000_0000_0000_0000_0000_0000_0000_0000_0000_0064;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] z;
    logic [M-1:0] exp;
    logic         exp_err;
    logic         exact;
    int           t0;
  } req_t;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  req_t sb_q[$];

  ecc_affine_conv_if #(.W(W)) bus ();

  ecc_affine_conv #(.M(M), .W(W), .POLY(POLY)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .conv  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] p, input logic [M-1:0] q);
    logic [M:0] acc;
    logic [M:0] sh;
    acc = '0;
    sh  = {1'b0, p};
    for (int i = 0; i < M; i++) begin
      if (q[i]) acc = acc ^ sh;
      sh = sh << 1;
      if (sh[M]) sh = sh ^ POLY;
    end
    return acc[M-1:0];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_true(input string name, input logic cond, input int val);
    checks++;
    if (cond !== 1'b1) begin
      errors++;
      $display("FAIL %s: got %0d, condition not met", name, val);
    end
  endtask

  // Call at a negedge while the DUT is idle; returns one negedge later.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] z,
                       input logic [M-1:0] exp, input logic exp_err, input logic exact);
    req_t r;
    bus.conv_start = 1'b1;
    bus.x_in       = x;
    bus.z_in       = z;
    r.x = x; r.z = z; r.exp = exp; r.exp_err = exp_err; r.exact = exact; r.t0 = cyc;
    sb_q.push_back(r);
    @(negedge clk);
    bus.conv_start = 1'b0;
    bus.x_in       = {W{1'b1}};
    bus.z_in       = {W{1'b1}};
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_true(name, sb_q.size() == 0, n);
    sb_q.delete();
  endtask

  task automatic run(input string name, input logic [W-1:0] x, input logic [W-1:0] z,
                     input logic [M-1:0] exp, input logic exp_err, input logic exact);
    @(negedge clk);
    issue(x, z, exp, exp_err, exact);
    wait_idle(name);
  endtask

  // Monitor: every conv_done must match the oldest outstanding request.
  initial begin
    req_t r;
    int   lat;
    forever begin
      @(negedge clk);
      if (bus.conv_done) begin
        check_true("done_has_request", sb_q.size() != 0, sb_q.size());
        if (sb_q.size() != 0) begin
          r   = sb_q.pop_front();
          lat = cyc - r.t0;
          check("conv_err", {{(W-1){1'b0}}, bus.conv_err}, {{(W-1){1'b0}}, r.exp_err});
          check("aff_pad", {{M{1'b0}}, bus.aff_x[W-1:M]}, {W{1'b0}});
          if (r.exact) begin
            check("aff_x", bus.aff_x, {{(W-M){1'b0}}, r.exp});
          end else begin
            check("aff_x_times_z", {{(W-M){1'b0}}, gf_mul(bus.aff_x[M-1:0], r.z[M-1:0])},
                  {{(W-M){1'b0}}, r.x[M-1:0]});
          end
          if (r.exp_err) begin
            check("err_latency", W'(lat), W'(2));
          end else begin
            check_true("latency", (lat >= 3) && (lat <= 328), lat);
          end
          check("busy_at_done", {{(W-1){1'b0}}, bus.conv_busy}, {{(W-1){1'b0}}, 1'b1});
        end
      end
    end
  end

  initial begin
    logic [191:0] rx, rz;
    int           n;
    rst_n          = 1'b0;
    bus.conv_start = 1'b0;
    bus.x_in       = '0;
    bus.z_in       = '0;
    repeat (3) @(negedge clk);
    check("rst_aff_x", bus.aff_x, {W{1'b0}});
    check("rst_busy", {{(W-1){1'b0}}, bus.conv_busy}, {W{1'b0}});
    check("rst_done", {{(W-1){1'b0}}, bus.conv_done}, {W{1'b0}});
    check("rst_err", {{(W-1){1'b0}}, bus.conv_err}, {W{1'b0}});
    rst_n = 1'b1;

    run("x5_z1", 176'h5, 176'h1, 163'h5, 1'b0, 1'b1);
    run("gx_gx", {13'h1ABC, GX}, {13'h0155, GX}, 163'h1, 1'b0, 1'b1);
    run("z_zero", 176'h1234_5678, {13'h1FFF, 163'h0}, 163'h0, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("err_hold", {{(W-1){1'b0}}, bus.conv_err}, {{(W-1){1'b0}}, 1'b1});
    check("err_aff_zero", bus.aff_x, {W{1'b0}});
    run("x0_z3", 176'h0, 176'h3, 163'h0, 1'b0, 1'b1);
    run("x2_z4", 176'h2, 176'h4, TINV, 1'b0, 1'b1);
    run("x1_z1", 176'h1, 176'h1, 163'h1, 1'b0, 1'b1);

    for (int i = 0; i < 64; i++) begin
      rx = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      rz = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      if (rz[M-1:0] == '0) rz[0] = 1'b1;
      run("random", rx[W-1:0], rz[W-1:0], '0, 1'b0, 1'b0);
    end

    // A start pulse in the middle of ITER must be ignored.
    @(negedge clk);
    issue({13'h0, GX}, 176'h1, GX, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("busy_mid_iter", {{(W-1){1'b0}}, bus.conv_busy}, {{(W-1){1'b0}}, 1'b1});
    bus.conv_start = 1'b1;
    bus.x_in       = 176'h5;
    bus.z_in       = 176'h1;
    @(negedge clk);
    bus.conv_start = 1'b0;
    wait_idle("mid_iter_start");

    // A start coinciding with conv_done must be ignored.
    @(negedge clk);
    issue(176'h2, 176'h4, TINV, 1'b0, 1'b1);
    n = 0;
    while (!bus.conv_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_true("done_seen", bus.conv_done, n);
    bus.conv_start = 1'b1;
    bus.x_in       = 176'h5;
    bus.z_in       = 176'h1;
    @(negedge clk);
    bus.conv_start = 1'b0;
    check("done_one_cycle", {{(W-1){1'b0}}, bus.conv_done}, {W{1'b0}});
    repeat (3) @(negedge clk);
    check("start_at_done_ignored", {{(W-1){1'b0}}, bus.conv_busy}, {W{1'b0}});
    check("aff_hold", bus.aff_x, {{(W-M){1'b0}}, TINV});

    // Reset mid-ITER abandons the work; a start right after release is accepted.
    @(negedge clk);
    bus.conv_start = 1'b1;
    bus.x_in       = 176'h7;
    bus.z_in       = 176'h9;
    @(negedge clk);
    bus.conv_start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_aff_x", bus.aff_x, {W{1'b0}});
    check("midrst_busy", {{(W-1){1'b0}}, bus.conv_busy}, {W{1'b0}});
    check("midrst_done", {{(W-1){1'b0}}, bus.conv_done}, {W{1'b0}});
    check("midrst_err", {{(W-1){1'b0}}, bus.conv_err}, {W{1'b0}});
    rst_n = 1'b1;
    issue({13'h0, GX}, {13'h0, GX}, 163'h1, 1'b0, 1'b1);
    wait_idle("start_after_reset");
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
